// File: rtl/cpu10_pkg.sv
// cpu10_pkg: shared definitions for the 10-bit CPU execute stage.
//   CPU_W       : datapath width
//   alu_op_e    : ALU operation encodings (ALU_ADD .. ALU_HALT, plus reserved)
//   idex_t      : decode->execute pipeline register contents
//   exwb_t      : execute->memory/writeback pipeline register contents
package cpu10_pkg;

    localparam int CPU_W = 10;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_NAND = 3'b011,
        ALU_SLR  = 3'b100,
        ALU_SLL  = 3'b101,
        ALU_HALT = 3'b110,
        ALU_RSVD = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic             valid;
        logic [CPU_W-1:0] op_a;
        logic [CPU_W-1:0] op_b;
        alu_op_e          alu_ctrl;
        logic [2:0]       rd;
        logic             reg_we;
        logic             mem_we;
        logic             mem_re;
        logic [CPU_W-1:0] store_data;
    } idex_t;

    typedef struct packed {
        logic             valid;
        logic [CPU_W-1:0] result;
        logic [CPU_W-1:0] store_data;
        logic [2:0]       rd;
        logic             reg_we;
        logic             mem_we;
        logic             mem_re;
    } exwb_t;

    // A bubble is valid=0 with every enable low; data fields are cleared too.
    localparam idex_t IDEX_BUBBLE = '0;
    localparam exwb_t EXWB_BUBBLE = '0;

endpackage

// File: rtl/cpu10_alu.sv
// cpu10_alu: purely combinational 10-bit ALU.
//   a_i, b_i    : operands
//   ctrl_i      : operation select (alu_op_e)
//   result_o    : result, mod 2^CPU_W
//   halt_o      : high for the HALT operation
module cpu10_alu
    import cpu10_pkg::*;
(
    input  logic [CPU_W-1:0] a_i,
    input  logic [CPU_W-1:0] b_i,
    input  alu_op_e          ctrl_i,
    output logic [CPU_W-1:0] result_o,
    output logic             halt_o
);

    logic [3:0] shamt;
    logic       shamt_oor;

    assign shamt     = b_i[3:0];
    // Shift amounts past the word width produce 0 rather than wrapping.
    assign shamt_oor = (shamt >= 4'(CPU_W));

    always_comb begin
        // NOTE: defaults assigned up front so no path through the case can infer a latch.
        result_o = '0;
        halt_o   = 1'b0;
        unique case (ctrl_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLT:  result_o = {{(CPU_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_NAND: result_o = ~(a_i & b_i);
            ALU_SLR:  result_o = shamt_oor ? '0 : (a_i >> shamt);
            ALU_SLL:  result_o = shamt_oor ? '0 : (a_i << shamt);
            ALU_HALT: halt_o   = 1'b1;
            ALU_RSVD: result_o = '0;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/cpu10_ex_pipe.sv
// cpu10_ex_pipe: execute stage of the 10-bit pipelined CPU.
// Holds the ID/EX register, the ALU and the EX/WB register, plus the sticky
// halt flag.
//   clk, rst          : clock, asynchronous active-high reset
//   id_*              : decoded instruction and stall/flush controls
//   ex_result         : combinational ALU result of the instruction in EX
//   wb_*              : registered EX/WB contents (result doubles as RAM address)
//   halted            : sticky halt flag, cleared only by rst
// W must equal cpu10_pkg::CPU_W; the pipeline structs are sized from it.
module cpu10_ex_pipe
    import cpu10_pkg::*;
#(
    parameter int W = CPU_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         id_valid,
    input  logic         id_stall,
    input  logic         id_flush,
    input  logic [W-1:0] id_op_a,
    input  logic [W-1:0] id_op_b,
    input  logic [2:0]   id_alu_ctrl,
    input  logic [2:0]   id_rd,
    input  logic         id_reg_we,
    input  logic         id_mem_we,
    input  logic         id_mem_re,
    input  logic [W-1:0] id_store_data,
    output logic [W-1:0] ex_result,
    output logic         wb_valid,
    output logic [W-1:0] wb_result,
    output logic [W-1:0] wb_store_data,
    output logic [2:0]   wb_rd,
    output logic         wb_reg_we,
    output logic         wb_mem_we,
    output logic         wb_mem_re,
    output logic         halted
);

    idex_t            idex_q, idex_d;
    exwb_t            exwb_q, exwb_d;
    logic             halted_q, halted_d;
    logic [CPU_W-1:0] alu_result;
    logic             alu_halt;

    cpu10_alu u_alu (
        .a_i      (idex_q.op_a),
        .b_i      (idex_q.op_b),
        .ctrl_i   (idex_q.alu_ctrl),
        .result_o (alu_result),
        .halt_o   (alu_halt)
    );

    // ID/EX next state: flush beats stall; a halted CPU only takes bubbles.
    always_comb begin
        idex_d = idex_q;
        if (id_flush || halted_q) begin
            idex_d = IDEX_BUBBLE;
        end else if (!id_stall) begin
            idex_d.valid      = id_valid;
            idex_d.op_a       = id_op_a;
            idex_d.op_b       = id_op_b;
            idex_d.alu_ctrl   = alu_op_e'(id_alu_ctrl);
            idex_d.rd         = id_rd;
            idex_d.reg_we     = id_reg_we & id_valid;
            idex_d.mem_we     = id_mem_we & id_valid;
            idex_d.mem_re     = id_mem_re & id_valid;
            idex_d.store_data = id_store_data;
        end
    end

    // EX/WB next state: a stall (without flush) drains a bubble into WB.
    always_comb begin
        exwb_d = EXWB_BUBBLE;
        if (!halted_q && !(id_stall && !id_flush)) begin
            exwb_d.valid      = idex_q.valid;
            exwb_d.result     = alu_result;
            exwb_d.store_data = idex_q.store_data;
            exwb_d.rd         = idex_q.rd;
            exwb_d.reg_we     = idex_q.reg_we & idex_q.valid;
            exwb_d.mem_we     = idex_q.mem_we & idex_q.valid;
            exwb_d.mem_re     = idex_q.mem_re & idex_q.valid;
        end
    end

    // Evaluated on the current ID/EX contents, so a concurrent flush cannot mask it.
    assign halted_d = halted_q | (idex_q.valid & alu_halt);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q   <= IDEX_BUBBLE;
            exwb_q   <= EXWB_BUBBLE;
            halted_q <= 1'b0;
        end else begin
            idex_q   <= idex_d;
            exwb_q   <= exwb_d;
            halted_q <= halted_d;
        end
    end

    assign ex_result     = alu_result;
    assign wb_valid      = exwb_q.valid;
    assign wb_result     = exwb_q.result;
    assign wb_store_data = exwb_q.store_data;
    assign wb_rd         = exwb_q.rd;
    assign wb_reg_we     = exwb_q.reg_we & exwb_q.valid & ~halted_q;
    assign wb_mem_we     = exwb_q.mem_we & exwb_q.valid & ~halted_q;
    assign wb_mem_re     = exwb_q.mem_re & exwb_q.valid & ~halted_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_cpu10_ex_pipe.sv
// tb_cpu10_ex_pipe: directed self-checking bench for cpu10_ex_pipe.
module tb_cpu10_ex_pipe;

    logic       clk;
    logic       rst;
    logic       id_valid, id_stall, id_flush;
    logic [9:0] id_op_a, id_op_b, id_store_data;
    logic [2:0] id_alu_ctrl, id_rd;
    logic       id_reg_we, id_mem_we, id_mem_re;
    logic [9:0] ex_result, wb_result, wb_store_data;
    logic       wb_valid, wb_reg_we, wb_mem_we, wb_mem_re, halted;
    logic [2:0] wb_rd;

    int errors = 0;
    int checks = 0;

    cpu10_ex_pipe #(.W(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_stall      (id_stall),
        .id_flush      (id_flush),
        .id_op_a       (id_op_a),
        .id_op_b       (id_op_b),
        .id_alu_ctrl   (id_alu_ctrl),
        .id_rd         (id_rd),
        .id_reg_we     (id_reg_we),
        .id_mem_we     (id_mem_we),
        .id_mem_re     (id_mem_re),
        .id_store_data (id_store_data),
        .ex_result     (ex_result),
        .wb_valid      (wb_valid),
        .wb_result     (wb_result),
        .wb_store_data (wb_store_data),
        .wb_rd         (wb_rd),
        .wb_reg_we     (wb_reg_we),
        .wb_mem_we     (wb_mem_we),
        .wb_mem_re     (wb_mem_re),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] a, input logic [9:0] b,
                         input logic [2:0] ctrl, input logic [2:0] rd,
                         input logic rwe, input logic mwe, input logic mre,
                         input logic [9:0] sd);
        id_valid = v; id_op_a = a; id_op_b = b; id_alu_ctrl = ctrl; id_rd = rd;
        id_reg_we = rwe; id_mem_we = mwe; id_mem_re = mre; id_store_data = sd;
    endtask

    task automatic idle();
        drive(1'b0, 10'h0, 10'h0, 3'b000, 3'h0, 1'b0, 1'b0, 1'b0, 10'h0);
        id_stall = 1'b0;
        id_flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (ex_result !== 10'h0) begin errors++; $display("FAIL reset_ex_result: got %h want %h", ex_result, 10'h0); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
        checks++; if ({wb_reg_we, wb_mem_we, wb_mem_re} !== 3'b000) begin errors++; $display("FAIL reset_wb_enables: got %b want 000", {wb_reg_we, wb_mem_we, wb_mem_re}); end
        checks++; if ({wb_result, wb_store_data, wb_rd} !== 23'h0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", {wb_result, wb_store_data, wb_rd}); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        drive(1'b1, 10'd3, 10'd4, 3'b000, 3'd5, 1'b1, 1'b0, 1'b0, 10'h0);
        tick();
        checks++; if (ex_result !== 10'd7) begin errors++; $display("FAIL add_ex_result: got %h want %h", ex_result, 10'd7); end
        idle();
        tick();
        checks++; if (wb_result !== 10'd7) begin errors++; $display("FAIL add_wb_result: got %h want %h", wb_result, 10'd7); end
        checks++; if (wb_rd !== 3'd5) begin errors++; $display("FAIL add_wb_rd: got %h want 5", wb_rd); end
        checks++; if (wb_reg_we !== 1'b1) begin errors++; $display("FAIL add_wb_reg_we: got %b want 1", wb_reg_we); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL add_wb_valid: got %b want 1", wb_valid); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_drain_valid: got %b want 0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] a   [4];
        logic [9:0] b   [4];
        logic [2:0] op  [4];
        logic [9:0] exp [4];
        a[0] = 10'd2;   b[0] = 10'd5;   op[0] = 3'b001; exp[0] = 10'h3FD;
        a[1] = 10'h3FF; b[1] = 10'd1;   op[1] = 3'b010; exp[1] = 10'h001;
        a[2] = 10'd1;   b[2] = 10'h3FF; op[2] = 3'b010; exp[2] = 10'h000;
        a[3] = 10'h3FF; b[3] = 10'h3FF; op[3] = 3'b011; exp[3] = 10'h000;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) drive(1'b1, a[i], b[i], op[i], 3'(i), 1'b1, 1'b0, 1'b0, 10'h0);
            else idle();
            tick();
            if (i > 0) begin
                checks++; if (wb_result !== exp[i-1] || wb_valid !== 1'b1)
                    begin errors++; $display("FAIL b2b_wb_%0d: got %h/v%b want %h/v1", i-1, wb_result, wb_valid, exp[i-1]); end
            end
        end
        tick();
    endtask

    task automatic test_shifts();
        logic [9:0] a   [5];
        logic [9:0] b   [5];
        logic [2:0] op  [5];
        logic [9:0] exp [5];
        a[0] = 10'h001; b[0] = 10'd3;  op[0] = 3'b101; exp[0] = 10'h008;
        a[1] = 10'h200; b[1] = 10'd9;  op[1] = 3'b100; exp[1] = 10'h001;
        a[2] = 10'h001; b[2] = 10'd12; op[2] = 3'b101; exp[2] = 10'h000;
        a[3] = 10'h3FF; b[3] = 10'd10; op[3] = 3'b100; exp[3] = 10'h000;
        a[4] = 10'h3FF; b[4] = 10'd9;  op[4] = 3'b101; exp[4] = 10'h200;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, a[i], b[i], op[i], 3'd1, 1'b1, 1'b0, 1'b0, 10'h0);
            tick();
            checks++; if (ex_result !== exp[i]) begin errors++; $display("FAIL shift_%0d: got %h want %h", i, ex_result, exp[i]); end
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_store();
        drive(1'b1, 10'd2, 10'd1, 3'b000, 3'd0, 1'b0, 1'b1, 1'b0, 10'h155);
        tick();
        idle();
        tick();
        checks++; if (wb_result !== 10'd3) begin errors++; $display("FAIL store_addr: got %h want 3", wb_result); end
        checks++; if (wb_mem_we !== 1'b1 || wb_reg_we !== 1'b0) begin errors++; $display("FAIL store_we: got mem%b reg%b want mem1 reg0", wb_mem_we, wb_reg_we); end
        checks++; if (wb_store_data !== 10'h155) begin errors++; $display("FAIL store_data: got %h want 155", wb_store_data); end
        tick();
    endtask

    task automatic test_stall();
        drive(1'b1, 10'd10, 10'd1, 3'b000, 3'd2, 1'b1, 1'b0, 1'b0, 10'h0);
        tick();
        drive(1'b1, 10'd20, 10'd2, 3'b000, 3'd3, 1'b1, 1'b0, 1'b0, 10'h0);
        id_stall = 1'b1;
        tick();
        checks++; if (wb_valid !== 1'b0 || wb_reg_we !== 1'b0) begin errors++; $display("FAIL stall_bubble: got v%b we%b want v0 we0", wb_valid, wb_reg_we); end
        checks++; if (ex_result !== 10'd11) begin errors++; $display("FAIL stall_hold: got %h want %h", ex_result, 10'd11); end
        id_stall = 1'b0;
        tick();
        checks++; if (wb_result !== 10'd11 || wb_valid !== 1'b1 || wb_rd !== 3'd2) begin errors++; $display("FAIL stall_release: got %h/v%b/rd%0d want 00b/v1/rd2", wb_result, wb_valid, wb_rd); end
        idle();
        tick();
        checks++; if (wb_result !== 10'd22 || wb_rd !== 3'd3) begin errors++; $display("FAIL stall_next: got %h/rd%0d want 016/rd3", wb_result, wb_rd); end
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 10'd5, 10'd5, 3'b000, 3'd4, 1'b1, 1'b1, 1'b1, 10'h0AA);
        id_flush = 1'b1;
        tick();
        checks++; if (ex_result !== 10'h0) begin errors++; $display("FAIL flush_ex: got %h want 0", ex_result); end
        idle();
        tick();
        checks++; if ({wb_valid, wb_reg_we, wb_mem_we, wb_mem_re} !== 4'b0000) begin errors++; $display("FAIL flush_wb: got %b want 0000", {wb_valid, wb_reg_we, wb_mem_we, wb_mem_re}); end
        // Flush and stall together: ID/EX flushed, EX/WB still advances.
        drive(1'b1, 10'd7, 10'd8, 3'b000, 3'd6, 1'b1, 1'b0, 1'b0, 10'h0);
        tick();
        drive(1'b1, 10'd1, 10'd1, 3'b000, 3'd1, 1'b1, 1'b0, 1'b0, 10'h0);
        id_flush = 1'b1;
        id_stall = 1'b1;
        tick();
        checks++; if (wb_result !== 10'd15 || wb_valid !== 1'b1 || wb_reg_we !== 1'b1) begin errors++; $display("FAIL flush_stall_adv: got %h/v%b/we%b want 00f/v1/we1", wb_result, wb_valid, wb_reg_we); end
        checks++; if (ex_result !== 10'h0) begin errors++; $display("FAIL flush_stall_ex: got %h want 0", ex_result); end
        idle();
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_stall_drain: got v%b want v0", wb_valid); end
    endtask

    task automatic test_halt();
        drive(1'b1, 10'd9, 10'd9, 3'b110, 3'd0, 1'b0, 1'b0, 1'b0, 10'h0);
        tick();
        checks++; if (halted !== 1'b0 || ex_result !== 10'h0) begin errors++; $display("FAIL halt_in_ex: got h%b/%h want h0/000", halted, ex_result); end
        drive(1'b1, 10'd1, 10'd1, 3'b000, 3'd3, 1'b1, 1'b0, 1'b0, 10'h0);
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", halted); end
        checks++; if (wb_reg_we !== 1'b0 || wb_mem_we !== 1'b0) begin errors++; $display("FAIL halt_instr_en: got reg%b mem%b want 0 0", wb_reg_we, wb_mem_we); end
        drive(1'b1, 10'd2, 10'd2, 3'b000, 3'd2, 1'b1, 1'b1, 1'b0, 10'h0);
        tick();
        checks++; if (wb_reg_we !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL halt_add_blocked: got we%b v%b want 0 0", wb_reg_we, wb_valid); end
        tick();
        tick();
        checks++; if (halted !== 1'b1 || {wb_valid, wb_reg_we, wb_mem_we} !== 3'b000) begin errors++; $display("FAIL halt_sticky: got h%b en%b want h1 en000", halted, {wb_valid, wb_reg_we, wb_mem_we}); end
        #2 rst = 1'b1;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_rst_clear: got %b want 0", halted); end
        idle();
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 10'd100, 10'd23, 3'b000, 3'd7, 1'b1, 1'b1, 1'b1, 10'h2AA);
        tick();
        tick();
        checks++; if (wb_result !== 10'd123 || wb_reg_we !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %h/we%b want 07b/we1", wb_result, wb_reg_we); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({wb_valid, wb_reg_we, wb_mem_we, wb_mem_re} !== 4'b0000) begin errors++; $display("FAIL rstmid_en: got %b want 0000", {wb_valid, wb_reg_we, wb_mem_we, wb_mem_re}); end
        checks++; if ({wb_result, wb_store_data, wb_rd} !== 23'h0 || ex_result !== 10'h0) begin errors++; $display("FAIL rstmid_data: got %h/%h want 0/0", {wb_result, wb_store_data, wb_rd}, ex_result); end
        tick();
        checks++; if (wb_reg_we !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL rstmid_held: got we%b v%b want 0 0", wb_reg_we, wb_valid); end
        idle();
        #2 rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_add();
        test_back_to_back();
        test_shifts();
        test_store();
        test_stall();
        test_flush();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu10_ex_pipe.md
# cpu10_ex_pipe

Execute-stage datapath of the 10-bit pipelined CPU. It holds the decode→execute pipeline register, the combinational 10-bit ALU, and the execute→memory/writeback pipeline register. Decode drives it with already-read operands and control bits; the RAM and register-file write port consume its registered outputs. It also owns the sticky CPU halt flag.

## Interface
Parameters:
- `W`, default 10: datapath width. All arithmetic below assumes 10.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `id_valid`, input, 1: decode presents a real instruction.
- `id_stall`, input, 1: hold the ID/EX register and inject a bubble into EX/WB.
- `id_flush`, input, 1: load a bubble into ID/EX.
- `id_op_a`, input, 10: operand A (rs value).
- `id_op_b`, input, 10: operand B (rt value or extended immediate).
- `id_alu_ctrl`, input, 3: ALU operation.
- `id_rd`, input, 3: destination, as {bank_sel, reg[1:0]}.
- `id_reg_we`, input, 1: register write enable.
- `id_mem_we`, input, 1: RAM write enable.
- `id_mem_re`, input, 1: RAM read enable.
- `id_store_data`, input, 10: store data (rt value).
- `ex_result`, output, 10: combinational ALU result of the instruction currently in EX.
- `wb_valid`, output, 1: the EX/WB register holds a real instruction.
- `wb_result`, output, 10: registered ALU result; also the RAM address.
- `wb_store_data`, output, 10: registered store data.
- `wb_rd`, output, 3: registered destination.
- `wb_reg_we`, output, 1: registered write enable, gated by valid and halt.
- `wb_mem_we`, output, 1: registered RAM write enable, gated by valid and halt.
- `wb_mem_re`, output, 1: registered RAM read enable, gated by valid and halt.
- `halted`, output, 1: sticky halt flag.

## Operation
ALU operations, selected by `alu_ctrl`. All results are mod 2^10.
- `000` ADD: A+B.
- `001` SUB: A−B.
- `010` SLT: 1 if signed(A) < signed(B), else 0.
- `011` NAND: ~(A&B).
- `100` SLR: A >> B[3:0], logical shift.
- `101` SLL: A << B[3:0].
- For either shift, an amount ≥10 gives 0.
- `110` HALT: result 0; internal `halt` = 1.
- `111` reserved: result 0; no halt.

Bubble definition:
- `valid`=0 and all enables 0.
- Data fields in a bubble are don't-care; they are cleared to 0.

ID/EX register update, in priority order:
- `id_flush`: load a bubble.
- else `id_stall`: hold current contents.
- else: load all `id_*` fields, with valid = `id_valid`.

EX/WB register update:
- If `id_stall` is high and `id_flush` is low: load a bubble.
- Otherwise: load the ALU result, store data, rd, the enables, and the valid bit of the ID/EX contents.

Halt:
- When a valid ID/EX instruction has ALU ctrl `110`, `halted` is set at the next edge.
- `halted` stays set until `rst`.
- While `halted`=1, both registers only load bubbles. All `wb_*` enables and `wb_valid` are 0 from the edge after `halted` rises.
- The HALT instruction itself has no enables set.

There is no operand forwarding in this block; hazards are handled upstream via `id_stall` and `id_flush`.

## Timing
- Reset: both registers become bubbles and every output register clears to 0. `halted`=0. `ex_result` then shows 0+0=0.
- Latency: an instruction presented before edge N enters ID/EX at edge N. `ex_result` is valid during cycle N. The `wb_*` outputs are valid after edge N+1.
- Throughput: one instruction per cycle when not stalled.
- Simultaneous events:
  - `id_flush` and `id_stall` together: the flush wins and EX/WB still advances.
  - HALT in EX together with a flush of ID/EX: `halted` still sets, because the halt is evaluated on the current ID/EX contents.
- Reset mid-operation: everything in flight is discarded immediately (asynchronous). No RAM or register write is issued after `rst` rises.

## Structure
- A shared package `cpu10_pkg` holds:
  - the ALU opcode constants (`ALU_ADD` through `ALU_HALT`);
  - the width constant;
  - packed structs `idex_t` and `exwb_t`.
- Sub-module `cpu10_alu`: purely combinational ALU with inputs A, B and ctrl, and outputs result and halt.
- The two pipeline registers are `always_ff` blocks in the top module.

## Test plan
- ADD: A=3, B=4, ctrl `000`, rd=5, reg_we=1 → `ex_result`=7 in cycle N. After N+1: `wb_result`=7, `wb_rd`=5, `wb_reg_we`=1, `wb_valid`=1.
- SUB, SLT and NAND, back to back:
  - SUB 2−5 → `0x3FD`.
  - SLT `0x3FF` vs 1 → 1.
  - SLT 1 vs `0x3FF` → 0.
  - NAND `0x3FF`,`0x3FF` → 0.
  - Results appear on `wb_result` one per cycle.
- Shifts:
  - SLL `0x001` by 3 → `0x008`.
  - SLR `0x200` by 9 → `0x001`.
  - SLL by 12 → 0.
- Store: ADD A=2, B=1, mem_we=1, store_data=`0x155` → `wb_result`=3, `wb_mem_we`=1, `wb_store_data`=`0x155`.
- Stall and flush:
  - Stall for 1 cycle → EX/WB shows a bubble for that cycle, then the held instruction appears once.
  - Flush → that instruction never asserts any `wb_*` enable.
- HALT, then `rst`:
  - HALT followed by ADD with reg_we=1 → `halted`=1 one edge after HALT is in EX; the following ADD yields `wb_reg_we`=0; `halted` stays 1.
  - Asserting `rst` mid-stream clears `halted` and all `wb_*` outputs immediately.
